// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8-bit even-parity frames, packs good bytes big-endian
// into 32-bit words, writes them to instruction memory and releases the CPU on start.
module uart_prog_loader #(
   parameter int DBIT         = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int AW           = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   input  logic          startbut,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_run,
   output logic [AW:0]   word_cnt,
   output logic          parity_err,
   output logic          frame_err,
   output logic          busy
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam int BW = $clog2(DBIT + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RUN} state_t;

   state_t            state, state_next;
   logic              rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]     clk_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DBIT-1:0]   shreg;
   logic              byte_bad;
   logic [1:0]        byte_cnt;
   logic [23:0]       word_buf;
   logic [AW-1:0]     wr_ptr;
   logic              start_pend;

   logic              fall, go, half_tick, bit_tick;
   logic              flush, run_now, data_shift, par_check, stop_done, sample_now;
   logic              wr_full, wr_any;
   logic [31:0]       padded;

   // rx is asynchronous; the previous synchronised value gives the falling-edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall      = rx_prev & ~rx_sync;
   assign go        = startbut | start_pend;
   assign half_tick = (clk_cnt == CW'(CLKS_PER_BIT / 2));
   assign bit_tick  = (clk_cnt == CW'(CLKS_PER_BIT));
   assign busy      = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Start requests win over a new frame edge; a pending partial word delays RUN by one cycle
   always_comb begin
      state_next = state;
      flush      = 1'b0;
      run_now    = 1'b0;
      data_shift = 1'b0;
      par_check  = 1'b0;
      stop_done  = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               if (byte_cnt != 2'd0) begin
                  flush = 1'b1;
               end else begin
                  run_now    = 1'b1;
                  state_next = RUN;
               end
            end else if (fall) begin
               state_next = START;
            end
         end
         START:  if (half_tick) state_next = rx_sync ? IDLE : DATA;
         DATA: begin
            if (bit_tick) begin
               data_shift = 1'b1;
               if (bit_cnt == BW'(DBIT - 1)) state_next = PARITY;
            end
         end
         PARITY: begin
            if (bit_tick) begin
               par_check  = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               stop_done  = 1'b1;
               state_next = IDLE;
            end
         end
         RUN:     state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   assign sample_now = ((state == START) && half_tick) | data_shift | par_check | stop_done;
   assign wr_full    = stop_done && rx_sync && !byte_bad && (byte_cnt == 2'd3);
   assign wr_any     = wr_full | flush;

   always_comb begin
      case (byte_cnt)
         2'd1:    padded = {word_buf[7:0], 24'h0};
         2'd2:    padded = {word_buf[15:0], 16'h0};
         default: padded = {word_buf[23:0], 8'h0};
      endcase
   end

   // Bit timing, byte assembly, word packing and the memory write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_bad   <= 1'b0;
         byte_cnt   <= 2'd0;
         word_buf   <= '0;
         wr_ptr     <= '0;
         start_pend <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_run    <= 1'b0;
         word_cnt   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         mem_we <= 1'b0;

         if (state == IDLE || sample_now) clk_cnt <= CW'(1);
         else if (state != RUN)            clk_cnt <= clk_cnt + CW'(1);

         if (state == IDLE)    bit_cnt <= '0;
         else if (data_shift)  bit_cnt <= bit_cnt + BW'(1);

         if (data_shift) shreg <= {rx_sync, shreg[DBIT-1:1]};

         if (par_check) begin
            byte_bad <= ((^shreg) != rx_sync);
            if ((^shreg) != rx_sync) parity_err <= 1'b1;
         end

         if (stop_done) begin
            if (!rx_sync) frame_err <= 1'b1;
            if (rx_sync && !byte_bad && byte_cnt != 2'd3) begin
               word_buf <= {word_buf[15:0], shreg[7:0]};
               byte_cnt <= byte_cnt + 2'd1;
            end
         end

         if (busy && startbut) start_pend <= 1'b1;

         if (wr_any) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= flush ? padded : {word_buf, shreg[7:0]};
            wr_ptr    <= wr_ptr + AW'(1);
            byte_cnt  <= 2'd0;
            if (word_cnt != {1'b1, {AW{1'b0}}}) word_cnt <= word_cnt + (AW+1)'(1);
         end

         if (flush) start_pend <= 1'b1;

         if (run_now) begin
            cpu_run    <= 1'b1;
            start_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a byte-queue model predicts every memory write, which a
// per-cycle compare process checks, alongside directed literal checks.
module tb_uart_prog_loader;

   localparam int CPB = 16;
   localparam int AW  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rx = 1'b1;
   logic          startbut = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_run;
   logic [AW:0]   word_cnt;
   logic          parity_err;
   logic          frame_err;
   logic          busy;

   always #5 clk = ~clk;

   uart_prog_loader #(.DBIT(8), .CLKS_PER_BIT(CPB), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .startbut   (startbut),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_run    (cpu_run),
      .word_cnt   (word_cnt),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cnt;
   } wr_t;

   wr_t           exp_q[$];
   logic [7:0]    mdl_bytes[$];
   logic [AW-1:0] mdl_ptr;
   int            mdl_wcnt;
   bit            mdl_run, mdl_perr, mdl_ferr;
   logic [AW-1:0] last_addr;
   logic [31:0]   last_data;
   int            tests_run = 0;
   int            tests_failed = 0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // The model: good bytes queue up, and every four (or a flush) become one expected write
   function automatic void model_push_word();
      wr_t w;
      w.data = 32'h0;
      for (int i = 0; i < mdl_bytes.size(); i++) w.data[31 - 8*i -: 8] = mdl_bytes[i];
      w.addr  = mdl_ptr;
      mdl_ptr = mdl_ptr + 1'b1;
      if (mdl_wcnt < (1 << AW)) mdl_wcnt++;
      w.cnt = mdl_wcnt;
      exp_q.push_back(w);
      mdl_bytes.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] data, input bit par_ok, input bit stop_ok);
      if (!mdl_run) begin
         if (!par_ok)  mdl_perr = 1'b1;
         if (!stop_ok) mdl_ferr = 1'b1;
         if (par_ok && stop_ok) begin
            mdl_bytes.push_back(data);
            if (mdl_bytes.size() == 4) model_push_word();
         end
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      mdl_bytes.delete();
      mdl_ptr  = '0;
      mdl_wcnt = 0;
      mdl_run  = 1'b0;
      mdl_perr = 1'b0;
      mdl_ferr = 1'b0;
   endfunction

   task automatic apply_reset();
      rx       = 1'b1;
      startbut = 1'b0;
      reset    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_output("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check_output("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
      check_output("rst_mem_wdata", mem_wdata, 32'h0);
      check_output("rst_cpu_run", {31'h0, cpu_run}, 32'h0);
      check_output("rst_word_cnt", {23'h0, word_cnt}, 32'h0);
      check_output("rst_parity_err", {31'h0, parity_err}, 32'h0);
      check_output("rst_frame_err", {31'h0, frame_err}, 32'h0);
      check_output("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // One full frame: start, 8 data bits LSB first, parity (good or inverted), stop
   task automatic apply_stimulus(input logic [7:0] data, input bit par_ok, input bit stop_ok);
      model_byte(data, par_ok, stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (CPB / 2) @(negedge clk);
         if (i == 4) check_output("busy_mid_frame", {31'h0, busy}, mdl_run ? 32'h0 : 32'h1);
         repeat (CPB / 2) @(negedge clk);
      end
      rx = par_ok ? ^data : ~^data;
      repeat (CPB) @(negedge clk);
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic apply_start(input bit expect_flush);
      if (!mdl_run && mdl_bytes.size() != 0) model_push_word();
      mdl_run  = 1'b1;
      startbut = 1'b1;
      @(posedge clk);
      #1;
      startbut = 1'b0;
      if (expect_flush) begin
         check_output("flush_we", {31'h0, mem_we}, 32'h1);
         check_output("flush_cpu_run_low", {31'h0, cpu_run}, 32'h0);
         @(posedge clk);
         #1;
      end else begin
         check_output("start_no_write", {31'h0, mem_we}, 32'h0);
      end
      check_output("cpu_run_rise", {31'h0, cpu_run}, 32'h1);
      @(negedge clk);
   endtask

   task automatic check_idle_state(input string tag);
      repeat (2 * CPB) @(negedge clk);
      check_output({tag, "_pending_writes"}, exp_q.size(), 32'h0);
      check_output({tag, "_word_cnt"}, {23'h0, word_cnt}, mdl_wcnt);
      check_output({tag, "_parity_err"}, {31'h0, parity_err}, {31'h0, mdl_perr});
      check_output({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, mdl_ferr});
      check_output({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   // Every write strobe must match the next predicted write; unpredicted writes are failures
   always @(negedge clk) begin
      if (reset && mem_we) begin
         last_addr = mem_addr;
         last_data = mem_wdata;
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_output("write_addr", {24'h0, mem_addr}, {24'h0, e.addr});
            check_output("write_data", mem_wdata, e.data);
            check_output("write_word_cnt", {23'h0, word_cnt}, e.cnt);
         end
      end
      if (reset && mdl_run && busy) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL busy_in_run: got 1, expected 0");
      end
   end

   initial begin
      model_reset();
      last_addr = '0;
      last_data = '0;

      // Basic word, then start with nothing pending
      apply_reset();
      apply_stimulus(8'h12, 1'b1, 1'b1);
      apply_stimulus(8'h34, 1'b1, 1'b1);
      apply_stimulus(8'h56, 1'b1, 1'b1);
      apply_stimulus(8'h78, 1'b1, 1'b1);
      check_idle_state("basic");
      check_output("basic_lit_data", last_data, 32'h12345678);
      check_output("basic_lit_addr", {24'h0, last_addr}, 32'h0);
      check_output("basic_lit_cnt", {23'h0, word_cnt}, 32'h1);
      apply_start(1'b0);

      // Twenty bytes with no idle gap between frames
      apply_reset();
      for (int i = 0; i < 20; i++) apply_stimulus(8'(i * 37 + 5), 1'b1, 1'b1);
      check_idle_state("b2b");
      check_output("b2b_lit_cnt", {23'h0, word_cnt}, 32'h5);
      check_output("b2b_lit_addr", {24'h0, last_addr}, 32'h4);

      // Parity error byte is dropped
      apply_reset();
      apply_stimulus(8'h01, 1'b0, 1'b1);
      apply_stimulus(8'hAA, 1'b1, 1'b1);
      apply_stimulus(8'hBB, 1'b1, 1'b1);
      apply_stimulus(8'hCC, 1'b1, 1'b1);
      apply_stimulus(8'hDD, 1'b1, 1'b1);
      check_idle_state("parity");
      check_output("parity_lit_data", last_data, 32'hAABBCCDD);
      check_output("parity_lit_flag", {31'h0, parity_err}, 32'h1);

      // Glitch (false start), then a framing error, then a clean word
      apply_reset();
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      check_idle_state("glitch");
      apply_stimulus(8'h55, 1'b1, 1'b0);
      check_idle_state("frame");
      check_output("frame_lit_flag", {31'h0, frame_err}, 32'h1);
      apply_stimulus(8'h01, 1'b1, 1'b1);
      apply_stimulus(8'h02, 1'b1, 1'b1);
      apply_stimulus(8'h03, 1'b1, 1'b1);
      apply_stimulus(8'h04, 1'b1, 1'b1);
      check_idle_state("after_frame");
      check_output("after_frame_lit_data", last_data, 32'h01020304);

      // Start with a partial word pending, then rx is ignored
      apply_reset();
      apply_stimulus(8'hDE, 1'b1, 1'b1);
      apply_stimulus(8'hAD, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      apply_start(1'b1);
      check_output("flush_lit_data", last_data, 32'hDEAD0000);
      check_output("flush_lit_addr", {24'h0, last_addr}, 32'h0);
      apply_stimulus(8'h99, 1'b1, 1'b1);
      check_idle_state("run");
      check_output("run_cpu_run_held", {31'h0, cpu_run}, 32'h1);

      // Reset in the middle of a frame after two words
      apply_reset();
      for (int i = 0; i < 8; i++) apply_stimulus(8'(8'hA0 + i), 1'b1, 1'b1);
      check_idle_state("two_words");
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      check_output("mid_data_busy", {31'h0, busy}, 32'h1);
      apply_reset();
      apply_stimulus(8'h11, 1'b1, 1'b1);
      apply_stimulus(8'h22, 1'b1, 1'b1);
      apply_stimulus(8'h33, 1'b1, 1'b1);
      apply_stimulus(8'h44, 1'b1, 1'b1);
      check_idle_state("post_reset");
      check_output("post_reset_lit_addr", {24'h0, last_addr}, 32'h0);
      check_output("post_reset_lit_data", last_data, 32'h11223344);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader sitting between the board `rx` pin and the CPU instruction memory inside `main`. Deserialises UART frames (start, DBIT data LSB-first, even parity, stop), packs every four good bytes into one 32-bit instruction word, and writes it to sequential instruction-memory addresses. On `startbut` it flushes any partial word and releases the CPU core with `cpu_run`.

## Interface
- `DBIT`, 8: data bits per frame.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; even, ≥ 4.
- `AW`, 8: instruction-memory word-address width.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `startbut`  in  1  start request, level, synchronous.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  AW  word address for `mem_wdata`.
- `mem_wdata`  out  32  packed instruction word.
- `cpu_run`  out  1  high once the CPU may fetch; stays high until reset.
- `word_cnt`  out  AW+1  number of words written since reset.
- `parity_err`  out  1  sticky: at least one frame failed parity.
- `frame_err`  out  1  sticky: at least one frame had stop bit = 0.
- `busy`  out  1  high while a frame is being received.

## Operation
- `rx` passes through a 2-flop synchroniser before any use; the synchronised value resets to 1.
- Receiver FSM states: IDLE, START, DATA, PARITY, STOP, RUN.
- IDLE: a synchronised 1→0 transition moves to START with the bit counter cleared.
- START: wait CLKS_PER_BIT/2 cycles, then sample. On 0, go to DATA. On 1, it is a false start: return to IDLE and change no state.
- DATA: sample every CLKS_PER_BIT cycles. Shift in DBIT bits LSB-first, then go to PARITY.
- PARITY: sample one bit. Required parity is even, i.e. the XOR of the data bits must equal the parity bit. On mismatch, mark the byte bad.
- STOP: sample one bit. A value of 0 sets `frame_err` and marks the byte bad. Either way, return to IDLE on the sample cycle.
- A bad byte is discarded: it does not advance the byte counter, and `parity_err`/`frame_err` latch.
- Good bytes are packed big-endian. The first byte of a word goes to [31:24] and the fourth to [7:0].
- After the fourth good byte:
  - `mem_we` pulses for one cycle with `mem_wdata` = packed word and `mem_addr` = current write pointer.
  - Then the pointer and `word_cnt` increment and the byte counter clears.
- Write pointer wraps from 2^AW−1 to 0. `word_cnt` saturates at 2^AW.
- Start handling: `startbut` high, sampled in IDLE, triggers the start sequence.
  - If the byte counter is non-zero, the partial word is written zero-padded in its low bytes (one `mem_we` pulse).
  - On the following cycle `cpu_run` rises. The FSM enters RUN.
- `startbut` asserted during START…STOP is latched and acted on when the FSM returns to IDLE.
- RUN is terminal until reset. `rx` is ignored, `busy` = 0 and no further writes occur.
- `busy` = 1 in START, DATA, PARITY and STOP.

## Timing
- Reset values:
  - Outputs: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `word_cnt`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - Internal: FSM=IDLE, byte counter=0, start-pending=0.
- Reset asserted mid-frame or in RUN aborts immediately. The partial byte and word are lost.
- Sample points, relative to the first cycle the synchronised `rx` is seen low: START sample at CLKS_PER_BIT/2, and bit k at CLKS_PER_BIT/2 + k·CLKS_PER_BIT, where k=1..DBIT+2.
- `mem_we` is registered and asserts the cycle after the STOP sample of the 4th good byte.
- `cpu_run` asserts 1 cycle after IDLE sees `startbut`. With a partial word pending, it asserts 2 cycles after, following the flush write.
- A new start edge is accepted on the cycle right after the STOP sample, so back-to-back frames with no idle gap are supported.
- A STOP sample coinciding with `startbut` high: the byte completes first, any resulting write occurs, then the start sequence follows.

## Test plan
- Reset, then send 0x12, 0x34, 0x56, 0x78 with correct parity → one `mem_we` pulse with `mem_addr`=0 and `mem_wdata`=0x12345678; `word_cnt`=1; no error flags.
- Send 20 good bytes back-to-back, no idle gap → writes at addresses 0..4, `word_cnt`=5, `busy` low only after the last stop bit.
- Send byte 0x01 with parity bit 0, then 0xAA, 0xBB, 0xCC, 0xDD → `parity_err`=1; the bad byte is dropped; word 0xAABBCCDD written at address 0.
- Frame with stop bit 0 → `frame_err`=1 and no byte counted. A 0-pulse of CLKS_PER_BIT/4 cycles on `rx` → false start, no flags raised.
- Send 0xDE, 0xAD, then pulse `startbut` → write 0xDEAD0000 at address 0, `cpu_run`=1 one cycle later; further `rx` frames are ignored.
- Assert reset mid-DATA after two words are written → all outputs return to their reset values; the next four bytes are written to address 0.
